// File: rtl/vproc_elem_red.sv
// Multi-lane masked reduction unit: folds LANES elements per beat into a scalar accumulator
// and returns one tagged result per instruction through a valid/ready output.
module vproc_elem_red #(
  parameter int unsigned LANES = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic                clk_i,
  input  logic                async_rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                in_first_i,
  input  logic                in_last_i,
  input  logic [2:0]          in_op_i,
  input  logic [1:0]          in_eew_i,
  input  logic [31:0]         in_init_i,
  input  logic [LANES*32-1:0] in_elems_i,
  input  logic [LANES-1:0]    in_mask_i,
  input  logic [TAG_W-1:0]    in_tag_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [31:0]         out_res_o,
  output logic [TAG_W-1:0]    out_tag_o
);

  localparam int unsigned Levels = $clog2(LANES);

  typedef enum logic [2:0] {
    OpSum, OpAnd, OpOr, OpXor, OpMinu, OpMin, OpMaxu, OpMax
  } op_e;

  // Zero-extend the low EEW bits; reserved EEW falls through to 32-bit.
  function automatic logic [31:0] trunc(input logic [1:0] eew, input logic [31:0] x);
    case (eew)
      2'b00:   trunc = {24'd0, x[7:0]};
      2'b01:   trunc = {16'd0, x[15:0]};
      default: trunc = x;
    endcase
  endfunction

  function automatic logic [31:0] sext(input logic [1:0] eew, input logic [31:0] x);
    case (eew)
      2'b00:   sext = {{24{x[7]}}, x[7:0]};
      2'b01:   sext = {{16{x[15]}}, x[15:0]};
      default: sext = x;
    endcase
  endfunction

  function automatic logic [31:0] sign_bit(input logic [1:0] eew);
    case (eew)
      2'b00:   sign_bit = 32'h0000_0080;
      2'b01:   sign_bit = 32'h0000_8000;
      default: sign_bit = 32'h8000_0000;
    endcase
  endfunction

  function automatic logic [31:0] identity(input op_e op, input logic [1:0] eew);
    unique case (op)
      OpAnd, OpMinu: identity = trunc(eew, '1);
      OpMin:         identity = sign_bit(eew) - 32'd1;
      OpMax:         identity = sign_bit(eew);
      default:       identity = '0;
    endcase
  endfunction

  // Operands arrive zero-extended from EEW bits; the result keeps that form.
  function automatic logic [31:0] red_op(input op_e op, input logic [1:0] eew,
                                         input logic [31:0] a, input logic [31:0] b);
    logic ltu;
    logic lts;
    ltu = a < b;
    lts = $signed(sext(eew, a)) < $signed(sext(eew, b));
    unique case (op)
      OpSum:  red_op = trunc(eew, a + b);
      OpAnd:  red_op = a & b;
      OpOr:   red_op = a | b;
      OpXor:  red_op = a ^ b;
      OpMinu: red_op = ltu ? a : b;
      OpMin:  red_op = lts ? a : b;
      OpMaxu: red_op = ltu ? b : a;
      default: red_op = lts ? b : a;
    endcase
  endfunction

  op_e         op;
  logic [31:0] ident;
  logic [31:0] seed;
  logic [31:0] red_val;
  logic        beat_fire;

  logic [31:0]      acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_res_q, out_res_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  assign op    = op_e'(in_op_i);
  assign ident = identity(op, in_eew_i);

  // Balanced tree: level 0 holds masked leaves, each level halves the node count.
  for (genvar l = 0; l <= Levels; l++) begin : g_lvl
    localparam int unsigned N = LANES >> l;
    logic [31:0] node [N];
    for (genvar j = 0; j < N; j++) begin : g_node
      if (l == 0) begin : g_leaf
        assign node[j] = in_mask_i[j] ? trunc(in_eew_i, in_elems_i[j*32 +: 32]) : ident;
      end else begin : g_inner
        assign node[j] = red_op(op, in_eew_i, g_lvl[l-1].node[2*j], g_lvl[l-1].node[2*j+1]);
      end
    end
  end

  assign seed      = in_first_i ? trunc(in_eew_i, in_init_i) : acc_q;
  assign red_val   = red_op(op, in_eew_i, seed, g_lvl[Levels].node[0]);
  assign in_ready_o = ~out_valid_q | out_ready_i;
  assign beat_fire = in_valid_i & in_ready_o;

  always_comb begin
    acc_d       = acc_q;
    out_valid_d = out_valid_q & ~out_ready_i;
    out_res_d   = out_res_q;
    out_tag_d   = out_tag_q;
    if (beat_fire) begin
      if (in_last_i) begin
        out_valid_d = 1'b1;
        out_res_d   = red_val;
        out_tag_d   = in_tag_i;
      end else begin
        acc_d = red_val;
      end
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_tag_q   <= '0;
    end else begin
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_res_o   = out_res_q;
  assign out_tag_o   = out_tag_q;

endmodule
